// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five pipeline registers. It also drops stale fetch
// returns after a redirect and keeps saturating stall and redirect counters.
//
// state | meaning
// IDLE  | no fetch outstanding, or the outstanding fetch completes this cycle
// WAIT  | fetch outstanding, and its instruction is still wanted
// DRAIN | fetch outstanding but squashed by a redirect; its return is discarded
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ireq_valid,
  input  logic             iresp_data_ok,
  input  logic             dreq_valid,
  input  logic             dresp_data_ok,
  input  logic             jump_flag,
  input  logic             load_use,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             stall_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             redirect_take,
  output logic             fetch_discard,
  output logic [1:0]       fetch_state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_redirect_cnt;

  logic w_drain;
  logic w_fetch_pending;
  logic w_d_busy;
  logic w_i_busy;
  logic w_redirect;
  logic w_stall_inc;

  assign w_drain         = (r_state == S_DRAIN);
  assign w_fetch_pending = ireq_valid & ~iresp_data_ok;
  assign w_d_busy        = dreq_valid & ~dresp_data_ok;
  assign w_i_busy        = w_drain | w_fetch_pending;
  assign w_redirect      = jump_flag & ~w_d_busy;
  assign w_stall_inc     = w_d_busy | (w_i_busy & ~w_drain);

  always_comb begin
    stall_pc      = 1'b0;
    stall_if_id   = 1'b0;
    stall_id_ex   = 1'b0;
    stall_ex_mem  = 1'b0;
    stall_mem_wb  = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    flush_ex_mem  = 1'b0;
    redirect_take = 1'b0;
    fetch_discard = 1'b0;
    if (!reset) begin
      fetch_discard = w_drain & iresp_data_ok;
      if (w_d_busy) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
        stall_mem_wb = 1'b1;
      end else if (w_redirect) begin
        flush_if_id   = 1'b1;
        flush_id_ex   = 1'b1;
        flush_ex_mem  = 1'b1;
        redirect_take = 1'b1;
      end else if (w_drain) begin
        // Back of the pipe keeps draining; if_id holds a bubble until the stale return lands.
        stall_pc    = 1'b1;
        flush_if_id = 1'b1;
      end else if (w_i_busy) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
        stall_mem_wb = 1'b1;
      end else if (load_use) begin
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fetch_pending) w_state_nxt = w_redirect ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        // A return that coincides with a redirect is killed by flush_if_id, so no drain is needed.
        if (iresp_data_ok)   w_state_nxt = S_IDLE;
        else if (w_redirect) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (iresp_data_ok) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_stall_cycles <= '0;
      r_redirect_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_stall_inc && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + CNT_ONE;
      if (redirect_take && (r_redirect_cnt != '1))
        r_redirect_cnt <= r_redirect_cnt + CNT_ONE;
    end
  end

  assign fetch_state  = r_state;
  assign stall_cycles = r_stall_cycles;
  assign redirect_cnt = r_redirect_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl at CNT_W=4: expected outputs are queued per step
// and compared at the following falling edge.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 4;

  // ctrl vector: stall pc,if_id,id_ex,ex_mem,mem_wb | flush if_id,id_ex,ex_mem | redirect_take | fetch_discard
  localparam logic [9:0] C_NONE  = 10'b00000_000_0_0;
  localparam logic [9:0] C_STALL = 10'b11111_000_0_0;
  localparam logic [9:0] C_REDIR = 10'b00000_111_1_0;
  localparam logic [9:0] C_DRAIN = 10'b10000_100_0_0;
  localparam logic [9:0] C_DISC  = 10'b10000_100_0_1;
  localparam logic [9:0] C_LU    = 10'b11000_010_0_0;
  // inputs: ireq_valid, iresp_data_ok, dreq_valid, dresp_data_ok, jump_flag, load_use
  localparam logic [5:0] I_NONE = 6'b000000;
  localparam logic [5:0] I_IREQ = 6'b100000;
  localparam logic [5:0] I_IOK  = 6'b010000;
  localparam logic [5:0] I_DREQ = 6'b001000;
  localparam logic [5:0] I_DOK  = 6'b000100;
  localparam logic [5:0] I_JUMP = 6'b000010;
  localparam logic [5:0] I_LU   = 6'b000001;

  logic clk = 1'b0;
  logic reset;
  logic ireq_valid, iresp_data_ok, dreq_valid, dresp_data_ok, jump_flag, load_use;
  logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem, redirect_take, fetch_discard;
  logic [1:0] fetch_state;
  logic [CNT_W-1:0] stall_cycles, redirect_cnt;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .iresp_data_ok(iresp_data_ok),
    .dreq_valid(dreq_valid), .dresp_data_ok(dresp_data_ok),
    .jump_flag(jump_flag), .load_use(load_use),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .redirect_take(redirect_take), .fetch_discard(fetch_discard),
    .fetch_state(fetch_state), .stall_cycles(stall_cycles), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]       ctrl;
    logic [1:0]       st;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] rc;
  } exp_t;

  exp_t q[$];
  int n_total = 0;
  int n_pass  = 0;
  logic [CNT_W-1:0] m_sc, m_rc;
  logic [9:0] obs_ctrl;

  assign obs_ctrl = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
                     flush_if_id, flush_id_ex, flush_ex_mem, redirect_take, fetch_discard};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, queue the expected outputs, compare at the falling edge,
  // then advance the bench's own counter model across the rising edge.
  task automatic step(input string tag, input logic rst, input logic [5:0] in,
                      input logic [9:0] ctrl, input logic [1:0] st, input logic sc_inc);
    exp_t e;
    reset = rst;
    {ireq_valid, iresp_data_ok, dreq_valid, dresp_data_ok, jump_flag, load_use} = in;
    e = {ctrl, st, m_sc, m_rc};
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    check({tag, "/ctrl"}, 32'(obs_ctrl), 32'(e.ctrl));
    check({tag, "/state"}, 32'(fetch_state), 32'(e.st));
    check({tag, "/stall_cycles"}, 32'(stall_cycles), 32'(e.sc));
    check({tag, "/redirect_cnt"}, 32'(redirect_cnt), 32'(e.rc));
    if (rst) begin
      m_sc = '0;
      m_rc = '0;
    end else begin
      if (sc_inc && m_sc != '1) m_sc = m_sc + 1'b1;
      if (ctrl[1] && m_rc != '1) m_rc = m_rc + 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_sc = '0;
    m_rc = '0;
    reset = 1'b1;
    {ireq_valid, iresp_data_ok, dreq_valid, dresp_data_ok, jump_flag, load_use} = I_IREQ | I_DREQ | I_JUMP | I_LU;
    repeat (2) @(posedge clk);
    #1;
    step("reset_hold", 1'b1, I_IREQ | I_DREQ | I_JUMP | I_LU, C_NONE, 2'd0, 1'b0);
    step("idle", 1'b0, I_NONE, C_NONE, 2'd0, 1'b0);

    // data stall outranks a pending redirect; redirect lands once the handshake completes
    for (int i = 0; i < 3; i++)
      step("dbusy_jump", 1'b0, I_DREQ | I_JUMP, C_STALL, 2'd0, 1'b1);
    step("dok_redirect", 1'b0, I_DREQ | I_DOK | I_JUMP, C_REDIR, 2'd0, 1'b0);
    step("after_redirect", 1'b0, I_NONE, C_NONE, 2'd0, 1'b0);

    // fetch outstanding, squashed in WAIT, stale return discarded in DRAIN
    step("ifetch_wait", 1'b0, I_IREQ, C_STALL, 2'd0, 1'b1);
    step("wait_jump", 1'b0, I_IREQ | I_JUMP, C_REDIR, 2'd1, 1'b1);
    step("drain_hold", 1'b0, I_NONE, C_DRAIN, 2'd2, 1'b0);
    step("drain_discard", 1'b0, I_IOK, C_DISC, 2'd2, 1'b0);
    step("back_idle", 1'b0, I_NONE, C_NONE, 2'd0, 1'b0);

    // IDLE straight to DRAIN; d_busy and repeated redirects inside DRAIN
    step("idle_to_drain", 1'b0, I_IREQ | I_JUMP, C_REDIR, 2'd0, 1'b1);
    step("drain_dbusy", 1'b0, I_DREQ | I_JUMP, C_STALL, 2'd2, 1'b1);
    step("drain_redirect", 1'b0, I_JUMP, C_REDIR, 2'd2, 1'b0);
    step("drain_redir_ok", 1'b0, I_JUMP | I_IOK, C_REDIR | 10'b1, 2'd2, 1'b0);
    step("drain_exit", 1'b0, I_NONE, C_NONE, 2'd0, 1'b0);

    step("load_use", 1'b0, I_LU, C_LU, 2'd0, 1'b0);
    step("lu_vs_jump", 1'b0, I_LU | I_JUMP, C_REDIR, 2'd0, 1'b0);

    // fetch completing with a redirect in IDLE: no drain, no discard
    step("idle_ok_jump", 1'b0, I_IREQ | I_IOK | I_JUMP, C_REDIR, 2'd0, 1'b0);
    step("idle_ok_after", 1'b0, I_NONE, C_NONE, 2'd0, 1'b0);

    // WAIT + redirect + return in the same cycle goes back to IDLE
    step("wait2_enter", 1'b0, I_IREQ, C_STALL, 2'd0, 1'b1);
    step("wait_ok_jump", 1'b0, I_IREQ | I_IOK | I_JUMP, C_REDIR, 2'd1, 1'b0);
    step("wait_ok_after", 1'b0, I_NONE, C_NONE, 2'd0, 1'b0);

    // WAIT persists without a request until the response
    step("wait3_enter", 1'b0, I_IREQ, C_STALL, 2'd0, 1'b1);
    step("wait_idle_in", 1'b0, I_NONE, C_NONE, 2'd1, 1'b0);
    step("wait_resp", 1'b0, I_IOK, C_NONE, 2'd1, 1'b0);
    step("wait_resp_after", 1'b0, I_NONE, C_NONE, 2'd0, 1'b0);

    for (int i = 0; i < 20; i++)
      step("dbusy_sat", 1'b0, I_DREQ, C_STALL, 2'd0, 1'b1);
    step("sat_hold", 1'b0, I_NONE, C_NONE, 2'd0, 1'b0);
    check("stall_cycles_saturated", 32'(stall_cycles), 32'd15);

    // reset while draining: back to IDLE and the late response is not discarded
    step("rst_drain_go", 1'b0, I_IREQ | I_JUMP, C_REDIR, 2'd0, 1'b1);
    step("rst_in_drain", 1'b1, I_IOK | I_JUMP, C_NONE, 2'd2, 1'b0);
    step("rst_late_resp", 1'b0, I_IOK, C_NONE, 2'd0, 1'b0);
    check("counters_cleared", 32'({stall_cycles, redirect_cnt}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
